// File: rtl/asteroid_pkg.sv
// Shared types and constants for the asteroid playfield and collision stages.
package asteroid_pkg;

    localparam int          GRID_N    = 16;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DEAD
    } state_t;

    // Right-shifting Galois step
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
    endfunction

endpackage

// File: rtl/asteroid_field_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
import asteroid_pkg::*;

module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/asteroid_field.sv
// Scrolling 16x16 asteroid playfield with ship tracking and overlap grid.
import asteroid_pkg::*;

module asteroid_field #(
    parameter int          TICK_DIV       = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [3:0]  SHIP_START_COL = 4'd7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   left,
    input  logic                   right,
    input  logic                   spawn_en,
    input  logic                   collide,
    output logic [15:0][15:0]      field_out,
    output logic [15:0][15:0]      overlap,
    output logic [3:0]             ship_col,
    output logic                   playing,
    output logic [15:0]            score
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      state;
    grid_t       field;
    logic [15:0] tick;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nx;
    logic [15:0] row0;
    logic [3:0]  mv_col;
    logic        go;
    logic        wrap;

    assign go   = start && (state != PLAY);
    assign wrap = (tick == TICK_LAST);

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (go),
        .en    ((state == PLAY) && !collide),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // New row uses the value the LFSR steps to on the scroll edge
    assign lfsr_nx = lfsr_next(lfsr_q);
    assign row0    = spawn_en ? (lfsr_nx & {lfsr_nx[7:0], lfsr_nx[15:8]})
                              : 16'h0;

    always_comb begin
        mv_col = ship_col;
        if (left && !right && ship_col != 4'd0) begin
            mv_col = ship_col - 4'd1;
        end else if (right && !left && ship_col != 4'd15) begin
            mv_col = ship_col + 4'd1;
        end
    end

    always_comb begin
        overlap = '0;
        overlap[GRID_N-1][ship_col] = field[GRID_N-1][ship_col];
    end

    assign field_out = field;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            playing  <= 1'b0;
            field    <= '0;
            ship_col <= SHIP_START_COL;
            score    <= 16'h0;
            tick     <= 16'h0;
        end else if (go) begin
            state    <= PLAY;
            playing  <= 1'b1;
            field    <= '0;
            ship_col <= SHIP_START_COL;
            score    <= 16'h0;
            tick     <= 16'h0;
        end else if (state == PLAY) begin
            if (collide) begin
                state   <= DEAD;
                playing <= 1'b0;
            end else begin
                ship_col <= mv_col;
                if (wrap) begin
                    tick  <= 16'h0;
                    field <= {field[GRID_N-2:0], row0};
                    if (score != 16'hFFFF) begin
                        score <= score + 16'd1;
                    end
                end else begin
                    tick <= tick + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/asteroid_field.md
Name: asteroid_field

Overview:
- Upstream stage of the collision checker. Holds the 16x16 asteroid playfield and scrolls it down one row per game tick.
- Spawns new asteroid rows at the top from an LFSR and tracks the ship column on the bottom row.
- Produces the 16x16 overlap grid (field AND ship mask) that the collision stage ORs into a single `collide` bit.
- Consumes that `collide` bit to freeze the game.

Parameters:
- TICK_DIV, 16, clock cycles per scroll tick (2..65535); the board build overrides it to a large value.
- LFSR_SEED, 16'hACE1, reset/restart value of the spawn LFSR; must be non-zero.
- SHIP_START_COL, 7, ship column after reset and on every start.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: begin/restart a game
- left  in  1  single-cycle pulse: move ship one column toward col 0
- right  in  1  single-cycle pulse: move ship one column toward col 15
- spawn_en  in  1  1 = new top rows come from the LFSR; 0 = new top rows are all-zero (used by the test bench)
- collide  in  1  from the collision stage: OR of `overlap`
- field_out  out  [15:0][15:0]  playfield, indexed [row][col]; row 0 is top, row 15 is the ship row
- overlap  out  [15:0][15:0]  `field_out` AND ship mask (only row 15, col `ship_col` can be set)
- ship_col  out  4  current ship column
- playing  out  1  high in PLAY
- score  out  16  scroll ticks survived, saturating at 16'hFFFF

Behaviour:
- Reset (async, active-high) sets: state IDLE, field all 0, ship_col = SHIP_START_COL, score 0, tick counter 0, LFSR = LFSR_SEED. All outputs are therefore 0 except ship_col.
- `overlap` is combinational from registered field and ship_col, with zero added latency. The loop overlap -> collide -> state is broken by the state register, giving one cycle from overlap to freeze.
- FSM IDLE / PLAY / DEAD:
  - IDLE: field held at 0. `start` -> PLAY.
  - PLAY: moves, tick counting and scrolling are active. `collide` -> DEAD on the next edge.
  - DEAD: field, ship_col and score are frozen. `start` -> PLAY.
- Any `start` entering PLAY (from IDLE or DEAD), on the same edge: field cleared, ship_col = SHIP_START_COL, score 0, tick counter 0, LFSR = LFSR_SEED. The game is reproducible from start.
- `start` while in PLAY is ignored.
- Tick counter, PLAY only: counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and a scroll occurs on that edge.
  - The first scroll after start is at edge TICK_DIV.
- Scroll:
  - Rows shift down: row r <= row r-1 for r = 15..1.
  - Old row 15 is discarded.
  - Row 0 <= spawn_en ? (lfsr & {lfsr[7:0], lfsr[15:8]}) : 16'h0, giving about 25% density.
  - score <= score + 1, saturating.
- LFSR: 16-bit Galois, polynomial 0xB400. Advances every cycle in PLAY and holds otherwise.
- Moves, PLAY only, any cycle:
  - `left`: ship_col - 1, saturating at 0.
  - `right`: ship_col + 1, saturating at 15.
  - `left` and `right` together: no move.
  - A move and a scroll on the same edge both apply.
- Priority in PLAY when `collide` = 1: the DEAD transition wins. No scroll, no move, no score increment and no LFSR advance on that edge.
- Collisions arise two ways:
  - An asteroid scrolls from row 14 into row 15 at ship_col.
  - The ship moves onto an occupied row-15 cell.
  - Either case makes `overlap` non-zero the cycle after the edge; DEAD follows one edge later.
- Reset asserted mid-game returns everything to reset values immediately. It is not clock-qualified.

Decomposition:
- Shared package `asteroid_pkg` holds:
  - typedef grid_t = logic [15:0][15:0], also used by the collision stage
  - state enum {IDLE, PLAY, DEAD}
  - LFSR_POLY = 16'hB400
  - GRID_N = 16
- One sub-module, `lfsr16`: clk, reset, load (seed), en, seed; output q.

Test Plan:
- TICK_DIV=4. Reset -> field_out = 0, overlap = 0, ship_col = 7, playing = 0, score = 0. Pulse start -> playing = 1 next edge.
- spawn_en=0, force row 14 col 7 = 1 via a hierarchical preload in PLAY. Required sequence:
  - The next scroll puts the asteroid in row 15 and sets overlap[15][7] = 1.
  - collide rises; the next edge gives playing = 0.
  - Field and score stay frozen for 20 cycles.
- spawn_en=0, 10 ticks with no asteroids -> score = 10, field all 0. Assert left 9 times -> ship_col saturates at 0. Assert right 20 times -> ship_col saturates at 15. left and right together -> unchanged.
- spawn_en=1: after start, row 0 following the first scroll equals the model value (LFSR from ACE1 advanced 4 cycles, AND with its byte-swap). Restart from DEAD -> the identical row 0 sequence is reproduced.
- Hold collide = 1 on the exact edge where the tick counter is at 3 -> no scroll occurs, score is unchanged, state is DEAD.
- Assert reset asynchronously mid-PLAY (between edges) -> all outputs return to reset values before the next clk edge. Start afterwards -> normal play.
